// File: rtl/tree_nca_path_generator_pkg.sv
// Shared tree-routing definitions: width derivations, FSM states and digit extraction
// for the source-side NCA path generator.
package tree_nca_path_generator_pkg;

  localparam int MAX_W = 32;

  // ceil(log2(x)); a one-wide field is still needed when x <= 1
  function automatic int log2c(input int x);
    int r;
    r = 0;
    if (x <= 1) return 1;
    while ((1 << r) < x) r = r + 1;
    return r;
  endfunction

  function automatic int kwOf(input int k);
    return log2c(k);
  endfunction

  function automatic int lkwOf(input int k, input int l);
    return l * log2c(k);
  endfunction

  function automatic int lwOf(input int l);
    return log2c(l);
  endfunction

  function automatic int dspwOf(input int k);
    return log2c(k + 1);
  endfunction

  function automatic int upPortOf(input int k);
    return k;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN
  } pathState_e;

  function automatic logic [MAX_W-1:0] get_digit(input logic [MAX_W-1:0] addr, input int i,
                                                 input int kw);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - kw);
    return (addr >> (i * kw)) & mask;
  endfunction

endpackage

// File: rtl/tree_nca_path_generator_level_calc.sv
// Combinational NCA depth: leading equal digits (root first), path length and self flag.
module tree_nca_level_calc
  import tree_nca_path_generator_pkg::*;
#(
  parameter int K = 2,
  parameter int L = 2,
  localparam int Kw = kwOf(K),
  localparam int LKw = lkwOf(K, L),
  localparam int Lw = lwOf(L)
) (
  input  logic [LKw-1:0] src_i,
  input  logic [LKw-1:0] dst_i,
  output logic [Lw-1:0]  n_o,
  output logic [Lw:0]    pathLen_o,
  output logic           self_o
);

  int   cnt;
  logic stop;

  // Only the first L-1 digits are compared, which saturates n at L-1.
  always_comb begin
    cnt  = 0;
    stop = 1'b0;
    for (int i = 0; i < L - 1; i++) begin
      if (!stop && (get_digit(MAX_W'(src_i), i, Kw) == get_digit(MAX_W'(dst_i), i, Kw))) begin
        cnt = cnt + 1;
      end else begin
        stop = 1'b1;
      end
    end
    n_o       = Lw'(cnt);
    pathLen_o = (Lw + 1)'(2 * (L - 1 - cnt) + 1);
    self_o    = (src_i == dst_i);
  end

endmodule

// File: rtl/tree_nca_path_generator.sv
// Source-route expander: walks up from the source leaf to the NCA, then down to the
// destination, emitting one (port, level) hop per accepted beat.
module tree_nca_path_generator
  import tree_nca_path_generator_pkg::*;
#(
  parameter int K = 2,
  parameter int L = 2,
  localparam int Kw = kwOf(K),
  localparam int LKw = lkwOf(K, L),
  localparam int Lw = lwOf(L),
  localparam int DSPw = dspwOf(K)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [LKw-1:0]  src_addr_i,
  input  logic [LKw-1:0]  dst_addr_i,
  output logic            hop_valid_o,
  input  logic            hop_ready_i,
  output logic [DSPw-1:0] hop_port_o,
  output logic [Lw-1:0]   hop_level_o,
  output logic            hop_last_o,
  output logic [Lw:0]     path_len_o,
  output logic            self_o
);

  pathState_e      state_q, state_d;
  logic [Lw-1:0]   level_q, level_d;
  logic [Lw-1:0]   n_q, n_d;
  logic [LKw-1:0]  dstAddr_q, dstAddr_d;
  logic [Lw:0]     pathLen_q, pathLen_d;
  logic            self_q, self_d;

  logic [Lw-1:0]   nCalc;
  logic [Lw:0]     pathLenCalc;
  logic            selfCalc;
  logic            accept;
  logic            topLevel;

  tree_nca_level_calc #(
    .K(K),
    .L(L)
  ) u_levelCalc (
    .src_i    (src_addr_i),
    .dst_i    (dst_addr_i),
    .n_o      (nCalc),
    .pathLen_o(pathLenCalc),
    .self_o   (selfCalc)
  );

  assign accept   = req_valid_i && (state_q == IDLE);
  assign topLevel = (level_q == Lw'(L - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      n_q       <= '0;
      dstAddr_q <= '0;
      pathLen_q <= '0;
      self_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      n_q       <= n_d;
      dstAddr_q <= dstAddr_d;
      pathLen_q <= pathLen_d;
      self_q    <= self_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    n_d       = n_q;
    dstAddr_d = dstAddr_q;
    pathLen_d = pathLen_q;
    self_d    = self_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dstAddr_d = dst_addr_i;
          n_d       = nCalc;
          pathLen_d = pathLenCalc;
          self_d    = selfCalc;
          level_d   = Lw'(L - 1);
          state_d   = (int'(nCalc) < L - 1) ? UP : DOWN;
        end
      end
      // UP only runs while n < L-1, so n+1 always fits in the level field
      UP: begin
        if (hop_ready_i) begin
          if (level_q == n_q + Lw'(1)) begin
            state_d = DOWN;
            level_d = n_q;
          end else begin
            level_d = level_q - Lw'(1);
          end
        end
      end
      DOWN: begin
        if (hop_ready_i) begin
          if (topLevel) begin
            state_d = IDLE;
          end else begin
            level_d = level_q + Lw'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    hop_valid_o = (state_q != IDLE);
    hop_port_o  = '0;
    hop_level_o = '0;
    hop_last_o  = 1'b0;
    case (state_q)
      UP: begin
        hop_port_o  = DSPw'(upPortOf(K));
        hop_level_o = level_q;
      end
      DOWN: begin
        hop_port_o  = DSPw'(get_digit(MAX_W'(dstAddr_q), int'(level_q), Kw));
        hop_level_o = level_q;
        hop_last_o  = topLevel;
      end
      default: ;
    endcase
  end

  assign path_len_o = pathLen_q;
  assign self_o     = self_q;

endmodule

// File: doc/tree_nca_path_generator.md
Name: tree_nca_path_generator

Overview:
- Source-side counterpart of the per-router tree NCA routing: at the injecting endpoint, it expands a (source, destination) endpoint-address pair into the full ordered list of per-hop output ports.
- Output is used to build source-routed headers and to check hop-by-hop routing in the bench.
- Walks up from the source leaf router to the nearest common ancestor, then down to the destination. Emits one hop per accepted beat on a valid/ready stream.
- Sits between the endpoint packet injector and the header-flit builder.

Parameters:
- K, 2, down ports per router; the up port index is K.
- L, 2, tree height. Level 0 is the root; level L-1 holds the leaf routers.
- Derived, not overridable: Kw=log2(K), LKw=L*Kw, Lw=log2(L), DSPw=log2(K+1). log2(x<=1)=1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid_i  in  1  path request
- req_ready_o  out  1  generator idle, can accept a request
- src_addr_i  in  LKw  source endpoint address; digit i = bits [(i+1)*Kw-1 : i*Kw]
- dst_addr_i  in  LKw  destination endpoint address, same digit layout
- hop_valid_o  out  1  hop_port_o / hop_level_o are valid
- hop_ready_i  in  1  consumer accepts the current hop
- hop_port_o  out  DSPw  output port at this hop: K = up, otherwise a down port
- hop_level_o  out  Lw  level of the router taking this hop
- hop_last_o  out  1  final hop of the path
- path_len_o  out  Lw+1  total hop count of the current path, 2*(L-1-n)+1
- self_o  out  1  src==dst (flag only; path still generated)

Behaviour:
- Reset (async, active-high): state=IDLE; req_ready_o=1; hop_valid_o=0; hop_last_o=0; hop_port_o=0; hop_level_o=0; path_len_o=0; self_o=0.
- Request acceptance:
  - Accept when req_valid_i & req_ready_o. Register src/dst on acceptance.
  - Compute n = count of leading equal digits from digit 0, saturated at L-1.
  - Compute self = (src==dst).
- FSM states: IDLE, UP, DOWN.
  - IDLE, on accept: go to UP if n<L-1 with level counter = L-1; otherwise go to DOWN with level = L-1.
  - UP: hop_port = K, hop_level = current level. On hop handshake, level decrements. When the level just used was n+1, go to DOWN with level = n.
  - DOWN: hop_port = {0, dst digit[level]} (zero-extended to DSPw). hop_last = (level==L-1). On handshake: if last, go to IDLE; else level increments.
- Latency: first hop valid in the cycle after acceptance. One hop per cycle under continuous hop_ready_i.
- req_ready_o=1 only in IDLE. No new request is accepted while a path is in flight, including the cycle of the last handshake.
- Stream stability: hop_valid_o is held with all hop outputs stable until hop_ready_i is asserted. Outputs must not change while stalled.
- path_len_o and self_o are valid from the first hop until the next acceptance.
- Inputs src/dst may change after acceptance without effect.
- Reset mid-path: immediately returns to IDLE, drops hop_valid_o, and discards the path.
- Hop count invariant: exactly 2*(L-1-n)+1 handshakes per request, with hop_last_o asserted on exactly the final one.
- L=1: there is no UP state visit; a single down hop is emitted.

Decomposition:
- Shared package (tree routing package) holds:
  - the log2 function and Kw/LKw/Lw/DSPw derivations;
  - the up-port constant UP_PORT=K;
  - the state enum {IDLE, UP, DOWN};
  - a digit-extract function get_digit(addr, i).
- One sub-module is natural: tree_nca_level_calc. It is combinational, takes src and dst, and outputs n, path_len and self.
- The FSM, level counter and output registers stay in the top module.

Test Plan:
- K=2, L=3, src=3'b010, dst=3'b011, hop_ready_i=1 -> hops (port, level) = (2,2), (2,1), (1,0), (1,1), (0,2); last on hop 5; path_len=5; first hop one cycle after accept.
- K=2, L=3, src=3'b010, dst=3'b110 -> single hop (1,2) with last=1; path_len=1; req_ready_o returns to 1 the cycle after the handshake.
- Same as the first case with hop_ready_i toggling 1,0,0,1,0,1,... -> identical hop sequence; outputs stable during every stall cycle; no hop lost or duplicated.
- src=dst=3'b101 -> self_o=1, single hop (1,2), last=1.
- Assert reset during the 3rd hop of the first case -> hop_valid_o=0 immediately and req_ready_o=1. A new request then produces a full fresh path.
- K=4, L=2 (DSPw=3), src=4'b0001, dst=4'b1110 -> hops (4,1), (2,0), (3,1); req_valid_i held high during the path is ignored until IDLE.
